// File: rtl/bytecode_fetch_unit.sv
// Bytecode byte source: delivers one JVM bytecode byte per start/ready handshake,
// reading big-endian 32-bit words from the bytecode RAM through a one-word buffer.
module bytecode_fetch_unit #(
    parameter int SIZE          = 1024,
    parameter int ADDRESS_WIDTH = 10,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pc_reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] code_len,
    output logic [7:0]               next_byte,
    output logic                     ready,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     done,
    output logic                     overrun,
    output logic [ADDRESS_WIDTH-3:0] mem_addr,
    output logic                     mem_rd,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] PC_BASE = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] PC_ONE  = ADDRESS_WIDTH'(1);

    if ((2 ** ADDRESS_WIDTH) < SIZE) begin : g_size_check
        $error("ADDRESS_WIDTH too small for SIZE");
    end

    state_t                   state;
    logic [31:0]              buf_data;
    logic [ADDRESS_WIDTH-3:0] buf_tag;
    logic                     buf_valid;
    logic                     discard;

    logic [ADDRESS_WIDTH-3:0] pc_word;
    logic                     hit;
    logic                     may_issue;

    // Big-endian byte lane select: offset 0 is the most significant byte.
    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] offset);
        logic [7:0] result;
        case (offset)
            2'd0:    result = word[31:24];
            2'd1:    result = word[23:16];
            2'd2:    result = word[15:8];
            2'd3:    result = word[7:0];
            default: result = 8'h00;
        endcase
        return result;
    endfunction

    assign pc_word   = pc[ADDRESS_WIDTH-1:2];
    assign mem_addr  = pc_word;
    assign done      = (pc >= code_len);
    assign hit       = buf_valid && (buf_tag == pc_word);
    // A stale response arriving this cycle clears discard, so a new read may go out now.
    assign may_issue = !discard || mem_valid;

    // Fetch state machine, byte buffer and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= PC_BASE;
            ready     <= 1'b0;
            next_byte <= 8'h00;
            mem_rd    <= 1'b0;
            overrun   <= 1'b0;
            buf_data  <= 32'h0000_0000;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
            discard   <= 1'b0;
        end else begin
            ready  <= 1'b0;
            mem_rd <= 1'b0;
            if (discard && mem_valid) begin
                discard <= 1'b0;
            end
            if (pc_reset) begin
                state     <= IDLE;
                pc        <= PC_BASE;
                buf_valid <= 1'b0;
                overrun   <= 1'b0;
                // An outstanding read must have its response swallowed later,
                // unless that response is arriving right now.
                if (state == WAIT) begin
                    discard <= !mem_valid;
                end else if ((state == REQ) && mem_rd) begin
                    discard <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        // The ready gate keeps a held start from producing back-to-back pulses.
                        if (start && !ready) begin
                            if (done) begin
                                ready     <= 1'b1;
                                next_byte <= 8'h00;
                                overrun   <= 1'b1;
                            end else if (hit) begin
                                ready     <= 1'b1;
                                next_byte <= select_byte(buf_data, pc[1:0]);
                                pc        <= pc + PC_ONE;
                            end else begin
                                state  <= REQ;
                                mem_rd <= may_issue;
                            end
                        end
                    end
                    REQ: begin
                        if (mem_rd) begin
                            state <= WAIT;
                        end else if (may_issue) begin
                            mem_rd <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (mem_valid) begin
                            buf_data  <= mem_rdata;
                            buf_tag   <= pc_word;
                            buf_valid <= 1'b1;
                            state     <= DELIVER;
                        end
                    end
                    DELIVER: begin
                        ready     <= 1'b1;
                        next_byte <= select_byte(buf_data, pc[1:0]);
                        pc        <= pc + PC_ONE;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bytecode_fetch_unit.sv
// Scoreboard bench for bytecode_fetch_unit: a latency-programmable word memory model,
// a model byte PC that predicts each delivered byte, and a monitor comparing on ready.
module tb_bytecode_fetch_unit;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          pc_reset;
    logic          start;
    logic [AW-1:0] code_len;
    logic [7:0]    next_byte;
    logic          ready;
    logic [AW-1:0] pc;
    logic          done;
    logic          overrun;
    logic [AW-3:0] mem_addr;
    logic          mem_rd;
    logic [31:0]   mem_rdata;
    logic          mem_valid;

    always #5 clk = ~clk;

    bytecode_fetch_unit #(.SIZE(1024), .ADDRESS_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .pc_reset(pc_reset), .start(start), .code_len(code_len),
        .next_byte(next_byte), .ready(ready), .pc(pc), .done(done), .overrun(overrun),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory model
    logic [31:0]   mem [0:255];
    int            lat         = 2;
    bit            bad_data    = 1'b0;
    int            rd_count    = 0;
    logic [AW-3:0] rd_addrs[$];
    int            rd_cycle    = 0;
    int            stale_cycle = 0;
    int            ncyc        = 0;

    initial begin : mem_model
        int          cnt;
        logic [31:0] pend;
        cnt       = 0;
        pend      = 32'h0;
        mem_valid = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            ncyc++;
            mem_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = pend;
                    if (pend == 32'hDEADBEEF) stale_cycle = ncyc;
                end
            end
            if (mem_rd) begin
                rd_count++;
                rd_addrs.push_back(mem_addr);
                rd_cycle = ncyc;
                cnt      = lat;
                pend     = bad_data ? 32'hDEADBEEF : mem[mem_addr];
            end
        end
    end

    // Scoreboard monitor
    logic [7:0] exp_q[$];
    int         ready_count = 0;
    logic       prev_ready  = 1'b0;

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (ready) begin
                ready_count++;
                check_val("ready_not_consecutive", {31'd0, prev_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("next_byte", {24'd0, next_byte}, {24'd0, e});
                end
            end
            prev_ready = ready;
        end
    end

    int mpc = 0;

    task automatic push_expected();
        logic [31:0] w;
        if (mpc >= int'(code_len)) begin
            exp_q.push_back(8'h00);
        end else begin
            w = mem[mpc / 4];
            exp_q.push_back(w[8 * (3 - (mpc % 4)) +: 8]);
            mpc++;
        end
    endtask

    task automatic do_start(input int exp_lat, input string tag);
        int n;
        @(negedge clk);
        push_expected();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n = 1;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check_val({tag, "_timeout"}, 32'd1, 32'd0);
            exp_q.delete();
        end else if (exp_lat > 0) begin
            check_val({tag, "_latency"}, n, exp_lat);
        end
    endtask

    task automatic apply_pc_reset();
        @(negedge clk);
        pc_reset = 1'b1;
        @(negedge clk);
        pc_reset = 1'b0;
        mpc      = 0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rc0;
        int rd0;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst      = 1'b1;
        pc_reset = 1'b1;
        start    = 1'b1;
        code_len = 10'd4;
        repeat (3) @(negedge clk);
        check_val("rst_pc", {22'd0, pc}, 32'd0);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_next_byte", {24'd0, next_byte}, 32'd0);
        check_val("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check_val("rst_overrun", {31'd0, overrun}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        rst      = 1'b0;
        pc_reset = 1'b0;
        start    = 1'b0;

        // Sequential read within one word
        mem[0]   = 32'hB200_0212;
        lat      = 2;
        rd_count = 0;
        rd_addrs.delete();
        do_start(5, "seq0");
        for (int i = 1; i < 4; i++) do_start(1, "seq_hit");
        check_val("seq_rd_count", rd_count, 32'd1);
        check_val("seq_rd_addr", {24'd0, rd_addrs[0]}, 32'd0);
        check_val("seq_done", {31'd0, done}, 32'd1);
        check_val("seq_pc", {22'd0, pc}, 32'd4);

        // Word crossing
        apply_pc_reset();
        mem[0]   = 32'h1122_3344;
        mem[1]   = 32'h5566_7788;
        code_len = 10'd8;
        rd_count = 0;
        rd_addrs.delete();
        for (int i = 0; i < 8; i++) do_start(((i % 4) == 0) ? 5 : 1, "cross");
        check_val("cross_rd_count", rd_count, 32'd2);
        check_val("cross_rd_addr0", {24'd0, rd_addrs[0]}, 32'd0);
        check_val("cross_rd_addr1", {24'd0, rd_addrs[1]}, 32'd1);

        // Overrun past end of method
        do_start(1, "ovr");
        check_val("ovr_flag", {31'd0, overrun}, 32'd1);
        check_val("ovr_pc", {22'd0, pc}, 32'd8);
        check_val("ovr_done", {31'd0, done}, 32'd1);
        apply_pc_reset();
        check_val("ovr_clear", {31'd0, overrun}, 32'd0);
        check_val("ovr_pc_reset", {22'd0, pc}, 32'd0);
        rd0 = rd_count;
        do_start(5, "refetch");
        check_val("refetch_rd_count", rd_count, rd0 + 1);
        check_val("refetch_rd_addr", {24'd0, rd_addrs[rd_addrs.size() - 1]}, 32'd0);

        // Abort mid-fetch: stale response must be swallowed
        apply_pc_reset();
        rd_count    = 0;
        stale_cycle = 0;
        bad_data    = 1'b1;
        lat         = 4;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        pc_reset = 1'b1;
        @(negedge clk);
        pc_reset = 1'b0;
        bad_data = 1'b0;
        lat      = 2;
        mpc      = 0;
        do_start(0, "abort_refetch");
        check_val("abort_rd_count", rd_count, 32'd2);
        check_val("abort_stale_seen", {31'd0, (stale_cycle != 0)}, 32'd1);
        check_val("abort_rd_after_stale", {31'd0, (rd_cycle > stale_cycle)}, 32'd1);
        check_val("abort_pc", {22'd0, pc}, 32'd1);

        // Start held high: each byte exactly once, no back-to-back ready
        apply_pc_reset();
        rc0 = ready_count;
        for (int i = 0; i < 4; i++) push_expected();
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check_val("held_drain", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        check_val("held_ready_count", ready_count - rc0, 32'd4);
        check_val("held_pc", {22'd0, pc}, 32'd4);

        // start together with pc_reset: start ignored
        @(negedge clk);
        start    = 1'b1;
        pc_reset = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        pc_reset = 1'b0;
        mpc      = 0;
        rc0      = ready_count;
        rd0      = rd_count;
        repeat (8) @(negedge clk);
        check_val("prio_no_ready", ready_count - rc0, 32'd0);
        check_val("prio_no_read", rd_count - rd0, 32'd0);
        check_val("prio_pc", {22'd0, pc}, 32'd0);

        // rst with pc_reset and start after building non-reset state
        code_len = 10'd0;
        do_start(1, "pre_rst_ovr");
        code_len = 10'd8;
        do_start(5, "pre_rst_byte");
        check_val("pre_rst_overrun", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        rst      = 1'b1;
        pc_reset = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        check_val("rst2_pc", {22'd0, pc}, 32'd0);
        check_val("rst2_ready", {31'd0, ready}, 32'd0);
        check_val("rst2_next_byte", {24'd0, next_byte}, 32'd0);
        check_val("rst2_mem_rd", {31'd0, mem_rd}, 32'd0);
        check_val("rst2_overrun", {31'd0, overrun}, 32'd0);
        rst      = 1'b0;
        pc_reset = 1'b0;
        start    = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bytecode_fetch_unit.md
Name: bytecode_fetch_unit

Overview:
- Upstream byte source for the JVM-to-ARM translation state machine.
- Delivers the JVM bytecode stream one byte per start/ready handshake: opcodes, wide prefixes and operand bytes.
- Reads 32-bit words from the bytecode RAM and holds the last word in a one-word buffer, so up to 4 sequential bytes cost one memory read.
- Tracks the byte PC and flags end-of-method.

Parameters:
- SIZE, 1024: bytecode RAM size in bytes.
- ADDRESS_WIDTH, 10: byte-address width. Must satisfy 2^ADDRESS_WIDTH >= SIZE.
- BASE_ADDR, 0: byte address loaded into pc on rst and pc_reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_reset  in  1  reload pc to BASE_ADDR, invalidate buffer, abort any fetch.
- start  in  1  request for the next byte. Sampled only in IDLE.
- code_len  in  ADDRESS_WIDTH  byte length of the method. Valid bytes are BASE_ADDR .. code_len-1.
- next_byte  out  8  delivered byte. Valid while ready=1 and held until the next delivery.
- ready  out  1  one-cycle pulse: next_byte valid.
- pc  out  ADDRESS_WIDTH  byte address of the next byte to deliver.
- done  out  1  combinational, equals (pc >= code_len).
- overrun  out  1  sticky: start was accepted while done=1.
- mem_addr  out  ADDRESS_WIDTH-2  word address = pc[ADDRESS_WIDTH-1:2].
- mem_rd  out  1  one-cycle read-request pulse.
- mem_rdata  in  32  read data.
- mem_valid  in  1  read data valid. Arrives >=1 cycle after mem_rd; latency unbounded.

Behaviour:
- Reset (rst=1) values: pc=BASE_ADDR, ready=0, next_byte=8'h00, mem_rd=0, overrun=0, buffer invalid, discard=0, state=IDLE.
- Priority: rst > pc_reset > start.
- Byte order is big-endian, as in JVM class files. pc[1:0]=0 selects rdata[31:24] and pc[1:0]=3 selects rdata[7:0].
- States: IDLE, REQ, WAIT, DELIVER.
- IDLE, start=1, done=1:
  - Next cycle: ready=1, next_byte=8'h00, overrun set.
  - pc unchanged, no memory access.
- IDLE, start=1, buffer hit (buffer valid and tag == pc[AW-1:2]):
  - Next cycle: ready=1, next_byte = selected byte, pc <= pc+1.
  - Latency 1, no memory access.
- IDLE, start=1, miss:
  - -> REQ: mem_rd=1 for exactly one cycle, mem_addr = pc word.
  - -> WAIT.
- WAIT, mem_valid=1: capture mem_rdata into the buffer, tag = pc word, buffer valid; -> DELIVER.
- DELIVER: ready=1, next_byte = selected byte, pc <= pc+1; -> IDLE.
- Miss latency from start: 3 + memory latency cycles.
- start outside IDLE is ignored; it is not queued.
- ready is never high for two consecutive cycles.
- pc increments modulo 2^ADDRESS_WIDTH. Crossing a word boundary (pc[1:0] 3 -> 0) makes the next start a miss.
- pc_reset (any state):
  - pc=BASE_ADDR, buffer invalid, overrun cleared, state=IDLE, ready=0 next cycle.
  - If asserted in WAIT, or in REQ once mem_rd has been issued: set discard.
  - While discard=1, the next mem_valid is dropped and then discard clears.
  - A new miss request while discard=1 is held in REQ (mem_rd not asserted) until discard clears.
- pc_reset and start in the same cycle: start is ignored.
- mem_valid outside WAIT with discard=0 is ignored.
- code_len may change only while in IDLE; done follows immediately.

Test Plan:
- Sequential read:
  - RAM word0=32'hB2_00_02_12, code_len=4, memory latency 2.
  - 4 starts -> bytes B2,00,02,12.
  - Exactly one mem_rd (addr 0).
  - First ready 5 cycles after start; rest 1 cycle after start.
  - done=1 after the 4th byte.
- Word crossing:
  - word0=11223344, word1=55667788, code_len=8.
  - 8 starts -> 11..88 in order.
  - Exactly 2 mem_rd, addrs 0 then 1.
- Overrun:
  - After the above, one more start -> ready with next_byte=00, overrun=1, pc stays 8.
  - Then pc_reset -> overrun=0, pc=0, and the next start refetches word0.
- Abort mid-fetch:
  - Issue start on a miss. Assert pc_reset in WAIT; mem_valid returns 3 cycles later with DEADBEEF.
  - No ready pulse, buffer stays invalid.
  - The following start issues a fresh mem_rd only after the stale mem_valid and returns the word-0 byte.
- Ignored/priority:
  - start held high continuously -> ready pulses are non-consecutive, and each byte is delivered exactly once.
  - start together with pc_reset -> no ready.
  - rst together with pc_reset and start -> all outputs at reset values.
